// File: rtl/dma_burst_writer.sv
// Purpose : executes one DMA burst: reads up to MAX_BURST dwords from the memory bus and writes them to video BRAM.
// Latency : accept->mem_req 1 cycle, beat->BRAM write 1 cycle, last beat->ack 2 cycles, zero-length accept->ack 1 cycle.
// Backpress: mem_req is held until mem_gnt; gaps in mem_rvalid stall the beat counter; the upstream request waits for ack.
//
// Ports
//   i_clk, i_rst            : single rising-edge clock, synchronous active-high reset
//   i_fetch_data            : burst request level, held by upstream until o_ack_fetch_data
//   i_src_addr / i_dst_addr : byte addresses of the burst; the two LSBs are ignored
//   i_burst_len             : requested dword count, clipped to MAX_BURST
//   o_ack_fetch_data        : one-cycle completion pulse
//   o_busy                  : high whenever the engine is not idle
//   o_mem_req/o_mem_addr/o_mem_len, i_mem_gnt : read request, held until granted
//   i_mem_rvalid/i_mem_rdata: returning read beats
//   o_videomem_we/o_videomem_addr/o_videomem_wdata : BRAM write port (dword addressed)

module dma_burst_writer #(
    parameter int SRC_ADDR_WIDTH = 16,
    parameter int DST_ADDR_WIDTH = 18,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST      = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    // command side
    input  logic                        i_fetch_data,
    input  logic [SRC_ADDR_WIDTH-1:0]   i_src_addr,
    input  logic [DST_ADDR_WIDTH-1:0]   i_dst_addr,
    input  logic [15:0]                 i_burst_len,
    output logic                        o_ack_fetch_data,
    output logic                        o_busy,
    // memory read bus
    output logic                        o_mem_req,
    output logic [SRC_ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [3:0]                  o_mem_len,
    input  logic                        i_mem_gnt,
    input  logic                        i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]       i_mem_rdata,
    // video BRAM write port
    output logic                        o_videomem_we,
    output logic [DST_ADDR_WIDTH-3:0]   o_videomem_addr,
    output logic [DATA_WIDTH-1:0]       o_videomem_wdata
);

    localparam int          VADDR_W     = DST_ADDR_WIDTH - 2;
    localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);
    localparam logic [3:0]  MAX_BURST_L = 4'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DATA  = 3'd2,
        S_FLUSH = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    // latched command
    logic [SRC_ADDR_WIDTH-1:0]  r_mem_addr;
    logic [3:0]                 r_len;
    logic [VADDR_W-1:0]         r_dst_dw;
    logic [3:0]                 r_cnt;

    // rearm flag: a request must be seen low before it can start another burst
    logic                       r_armed;

    // registered outputs
    logic                       r_ack;
    logic                       r_busy;
    logic                       r_mem_req;
    logic                       r_we;
    logic [VADDR_W-1:0]         r_vaddr;
    logic [DATA_WIDTH-1:0]      r_wdata;

    // combinational controls
    logic                       w_accept;
    logic                       w_beat;
    logic [3:0]                 w_len;
    logic                       w_last_beat;

    // Byte-lane bits of the addresses carry no meaning for a dword engine.
    logic                       w_unused_lsbs;
    assign w_unused_lsbs = &{1'b0, i_src_addr[1:0], i_dst_addr[1:0]};

    // Clip the requested length to what one bus burst can carry.
    assign w_len       = (i_burst_len > MAX_BURST_W) ? MAX_BURST_L : i_burst_len[3:0];
    assign w_last_beat = (r_cnt == (r_len - 4'd1));

    //--------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_beat       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_fetch_data && r_armed) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_len == 4'd0) ? S_ACK : S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                // Beats are only taken here; the FSM leaves DATA on the last
                // one, so any surplus beats land in FLUSH/ACK and are dropped.
                if (i_mem_rvalid) begin
                    w_beat = 1'b1;
                    if (w_last_beat) begin
                        w_next_state = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_next_state = S_ACK;
            end
            S_ACK: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_len      <= '0;
            r_dst_dw   <= '0;
            r_cnt      <= '0;
            r_armed    <= 1'b1;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_we       <= 1'b0;
            r_vaddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_state   <= w_next_state;

            // Status outputs are decoded from the next state so they line
            // up with the state they describe without a combinational path.
            r_busy    <= (w_next_state != S_IDLE);
            r_mem_req <= (w_next_state == S_REQ);
            r_ack     <= (w_next_state == S_ACK);
            r_we      <= w_beat;

            // A low sample always rearms, even in the ack cycle, so an
            // upstream that drops early is not locked out.
            if (!i_fetch_data) begin
                r_armed <= 1'b1;
            end else if (r_state == S_ACK) begin
                r_armed <= 1'b0;
            end

            if (w_accept) begin
                r_mem_addr <= {i_src_addr[SRC_ADDR_WIDTH-1:2], 2'b00};
                r_len      <= w_len;
                r_dst_dw   <= i_dst_addr[DST_ADDR_WIDTH-1:2];
                r_cnt      <= '0;
            end

            // BRAM address wraps naturally at the dword address width.
            if (w_beat) begin
                r_vaddr <= r_dst_dw + VADDR_W'(r_cnt);
                r_wdata <= i_mem_rdata;
                r_cnt   <= r_cnt + 4'd1;
            end
        end
    end

    assign o_ack_fetch_data = r_ack;
    assign o_busy           = r_busy;
    assign o_mem_req        = r_mem_req;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_len        = r_len;
    assign o_videomem_we    = r_we;
    assign o_videomem_addr  = r_vaddr;
    assign o_videomem_wdata = r_wdata;

endmodule

// File: tb/tb_dma_burst_writer.sv
// Purpose : directed, table-driven bench for dma_burst_writer.
// Latency : inputs change on the falling edge, outputs are sampled on the next falling edge.
// Backpress: memory grant and beat timing are scripted per vector.

module tb_dma_burst_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fetch_data;
    logic [15:0] src_addr;
    logic [17:0] dst_addr;
    logic [15:0] burst_len;
    logic        ack;
    logic        busy;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [3:0]  mem_len;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        vm_we;
    logic [15:0] vm_addr;
    logic [31:0] vm_wdata;

    dma_burst_writer dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_fetch_data     (fetch_data),
        .i_src_addr       (src_addr),
        .i_dst_addr       (dst_addr),
        .i_burst_len      (burst_len),
        .o_ack_fetch_data (ack),
        .o_busy           (busy),
        .o_mem_req        (mem_req),
        .o_mem_addr       (mem_addr),
        .o_mem_len        (mem_len),
        .i_mem_gnt        (mem_gnt),
        .i_mem_rvalid     (mem_rvalid),
        .i_mem_rdata      (mem_rdata),
        .o_videomem_we    (vm_we),
        .o_videomem_addr  (vm_addr),
        .o_videomem_wdata (vm_wdata)
    );

    // One vector: inputs for one cycle, and the outputs expected in the next.
    typedef struct {
        logic        fetch;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [15:0] src;
        logic [17:0] dst;
        logic [15:0] blen;
        logic [71:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] c_src;
    logic [17:0] c_dst;
    logic [15:0] c_len;

    // {ack, busy, req, mem_addr, mem_len, we, vaddr, wdata}
    function automatic logic [71:0] E(input logic a, input logic b, input logic r,
                                      input logic [15:0] ma, input logic [3:0] ml,
                                      input logic w, input logic [15:0] va, input logic [31:0] wd);
        return {a, b, r, ma, ml, w, va, wd};
    endfunction

    function automatic logic [71:0] outs();
        return {ack, busy, mem_req, mem_addr, mem_len, vm_we, vm_addr, vm_wdata};
    endfunction

    task automatic add(input logic f, input logic g, input logic rv,
                       input logic [31:0] rd, input logic [71:0] e);
        vec_t t;
        t.fetch = f;
        t.gnt   = g;
        t.rv    = rv;
        t.rdata = rd;
        t.src   = c_src;
        t.dst   = c_dst;
        t.blen  = c_len;
        t.exp   = e;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int req_cycles;
        int nw;
        int ack_n;
        int ack_at;
        int bad;

        //------------------------------------------------------------------
        // Vector table
        //------------------------------------------------------------------
        // Full burst: src 0x0100, dst 0x00400 (dword 0x0100), len 8.
        c_src = 16'h0100; c_dst = 18'h00400; c_len = 16'd8;
        add(1, 0, 0, 32'h0, E(0, 1, 1, 16'h0100, 4'd8, 0, 16'h0000, 32'h0));
        add(1, 1, 0, 32'h0, E(0, 1, 0, 16'h0100, 4'd8, 0, 16'h0000, 32'h0));
        for (int k = 0; k < 8; k++)
            add(1, 0, 1, 32'hA0 + 32'(k),
                E(0, 1, 0, 16'h0100, 4'd8, 1, 16'h0100 + 16'(k), 32'hA0 + 32'(k)));
        add(1, 0, 0, 32'h0, E(1, 1, 0, 16'h0100, 4'd8, 0, 16'h0107, 32'hA7));
        add(0, 0, 0, 32'h0, E(0, 0, 0, 16'h0100, 4'd8, 0, 16'h0107, 32'hA7));
        // Zero length: ack the cycle after accept; held request is not re-run.
        c_src = 16'h0200; c_dst = 18'h00800; c_len = 16'd0;
        add(1, 0, 0, 32'h0, E(1, 1, 0, 16'h0200, 4'd0, 0, 16'h0107, 32'hA7));
        add(1, 0, 0, 32'h0, E(0, 0, 0, 16'h0200, 4'd0, 0, 16'h0107, 32'hA7));
        add(1, 0, 0, 32'h0, E(0, 0, 0, 16'h0200, 4'd0, 0, 16'h0107, 32'hA7));
        add(0, 0, 0, 32'h0, E(0, 0, 0, 16'h0200, 4'd0, 0, 16'h0107, 32'hA7));
        // Length 12 clipped to 8; surplus beats in FLUSH/ACK are dropped.
        c_src = 16'h0300; c_dst = 18'h01000; c_len = 16'd12;
        add(1, 0, 0, 32'h0, E(0, 1, 1, 16'h0300, 4'd8, 0, 16'h0107, 32'hA7));
        add(1, 1, 0, 32'h0, E(0, 1, 0, 16'h0300, 4'd8, 0, 16'h0107, 32'hA7));
        for (int k = 0; k < 8; k++)
            add(1, 0, 1, 32'hB0 + 32'(k),
                E(0, 1, 0, 16'h0300, 4'd8, 1, 16'h0400 + 16'(k), 32'hB0 + 32'(k)));
        add(1, 0, 1, 32'hBF, E(1, 1, 0, 16'h0300, 4'd8, 0, 16'h0407, 32'hB7));
        add(1, 0, 1, 32'hBE, E(0, 0, 0, 16'h0300, 4'd8, 0, 16'h0407, 32'hB7));
        add(0, 0, 0, 32'h0,  E(0, 0, 0, 16'h0300, 4'd8, 0, 16'h0407, 32'hB7));
        // Wrap: dst dword 0xFFFF, len 2; src LSBs masked; beat during grant
        // cycle ignored; stray beats in IDLE never written.
        c_src = 16'h0013; c_dst = 18'h3FFFC; c_len = 16'd2;
        add(1, 0, 0, 32'h0,  E(0, 1, 1, 16'h0010, 4'd2, 0, 16'h0407, 32'hB7));
        add(1, 1, 1, 32'hEE, E(0, 1, 0, 16'h0010, 4'd2, 0, 16'h0407, 32'hB7));
        add(1, 0, 1, 32'hC0, E(0, 1, 0, 16'h0010, 4'd2, 1, 16'hFFFF, 32'hC0));
        add(1, 0, 1, 32'hC1, E(0, 1, 0, 16'h0010, 4'd2, 1, 16'h0000, 32'hC1));
        add(1, 0, 0, 32'h0,  E(1, 1, 0, 16'h0010, 4'd2, 0, 16'h0000, 32'hC1));
        add(0, 0, 1, 32'hDD, E(0, 0, 0, 16'h0010, 4'd2, 0, 16'h0000, 32'hC1));
        add(0, 0, 1, 32'hDE, E(0, 0, 0, 16'h0010, 4'd2, 0, 16'h0000, 32'hC1));

        //------------------------------------------------------------------
        // Reset state
        //------------------------------------------------------------------
        rst = 1'b1; fetch_data = 1'b0; src_addr = '0; dst_addr = '0; burst_len = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        step();
        chk("reset_state", outs(), 72'h0);
        rst = 1'b0;

        //------------------------------------------------------------------
        // Apply the table
        //------------------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            fetch_data = vecs[i].fetch;
            mem_gnt    = vecs[i].gnt;
            mem_rvalid = vecs[i].rv;
            mem_rdata  = vecs[i].rdata;
            src_addr   = vecs[i].src;
            dst_addr   = vecs[i].dst;
            burst_len  = vecs[i].blen;
            step();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;

        //------------------------------------------------------------------
        // Delayed grant (4 cycles late) and one idle cycle between beats
        //------------------------------------------------------------------
        src_addr = 16'h0400; dst_addr = 18'h00040; burst_len = 16'd3;
        fetch_data = 1'b1;
        step();
        req_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req) req_cycles++;
            mem_gnt = (i == 4);
            step();
        end
        mem_gnt = 1'b0;
        chk("dg_req_cycles", 72'(req_cycles), 72'd5);
        chk("dg_req_drop", 72'(mem_req), 72'd0);
        nw = 0; ack_n = 0; ack_at = -1;
        for (int k = 0; k < 10; k++) begin
            mem_rvalid = (k == 0 || k == 2 || k == 4);
            mem_rdata  = 32'hD0 + 32'(k / 2);
            step();
            if (vm_we) begin
                chk($sformatf("dg_waddr%0d", nw), 72'(vm_addr), 72'h0010 + 72'(nw));
                chk($sformatf("dg_wdata%0d", nw), 72'(vm_wdata), 72'hD0 + 72'(nw));
                nw++;
            end
            if (ack) begin
                ack_n++;
                ack_at = k + 1;
                fetch_data = 1'b0;
            end
        end
        mem_rvalid = 1'b0;
        chk("dg_writes", 72'(nw), 72'd3);
        chk("dg_acks", 72'(ack_n), 72'd1);
        chk("dg_ack_cycle", 72'(ack_at), 72'd6);

        //------------------------------------------------------------------
        // Rearm: request held after ack is not re-executed
        //------------------------------------------------------------------
        src_addr = 16'h0600; dst_addr = 18'h00100; burst_len = 16'd1;
        fetch_data = 1'b1;
        step();
        chk("ra_req_first", 72'(mem_req), 72'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        step();
        mem_rvalid = 1'b0;
        chk("ra_write", 72'({vm_we, vm_addr, vm_wdata}), 72'({1'b1, 16'h0040, 32'h55}));
        step();
        chk("ra_ack", 72'(ack), 72'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_req || busy || ack) bad++;
        end
        chk("ra_no_retrigger", 72'(bad), 72'd0);
        fetch_data = 1'b0;
        step();
        fetch_data = 1'b1;
        step();
        chk("ra_rearm_req", 72'(mem_req), 72'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h66;
        step();
        mem_rvalid = 1'b0;
        step();
        chk("ra_rearm_ack", 72'(ack), 72'd1);
        fetch_data = 1'b0;
        step();

        //------------------------------------------------------------------
        // Reset after 3 of 8 beats
        //------------------------------------------------------------------
        src_addr = 16'h0700; dst_addr = 18'h00200; burst_len = 16'd8;
        fetch_data = 1'b1;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h70 + 32'(k);
            step();
        end
        chk("rs_pre_write", 72'({vm_we, vm_addr}), 72'({1'b1, 16'h0082}));
        rst = 1'b1; fetch_data = 1'b0; mem_rdata = 32'h73;
        step();
        rst = 1'b0;
        chk("rs_outputs", outs(), 72'h0);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h74 + 32'(k);
            step();
            if (vm_we || ack || busy || mem_req) bad++;
        end
        mem_rvalid = 1'b0;
        chk("rs_no_activity", 72'(bad), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
